// File: rtl/mini_cpu.sv
// Single-cycle accumulator core with a 16-word program ROM and 16-byte data RAM.
// Define MINI_DEBUG_PORTS_EN to expose acc_dbg / pc_dbg / z_dbg state views.
module mini_cpu #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic clk,
    input  logic rst,
    output logic L,
    output logic W,
    output logic R,
    output logic S
`ifdef MINI_DEBUG_PORTS_EN
    ,
    output logic [DATA_W-1:0] acc_dbg,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic              z_dbg
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LDA  = 4'h2,
        OP_STA  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_JMP  = 4'h6,
        OP_JZ   = 4'h7,
        OP_HLT  = 4'h8,
        OP_ADDI = 4'h9
    } op_t;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
        case (a)
            ADDR_W'(0): rom = DATA_W'(8'h15);
            ADDR_W'(1): rom = DATA_W'(8'h30);
            ADDR_W'(2): rom = DATA_W'(8'h13);
            ADDR_W'(3): rom = DATA_W'(8'h40);
            ADDR_W'(4): rom = DATA_W'(8'h31);
            ADDR_W'(5): rom = DATA_W'(8'h21);
            ADDR_W'(6): rom = DATA_W'(8'h80);
            default:    rom = '0;
        endcase
    endfunction

    state_t              state, state_d;
    logic [ADDR_W-1:0]   pc, pc_d;
    logic [DATA_W-1:0]   acc, acc_d;
    logic                z, z_d, c, c_d;
    logic [DATA_W-1:0]   ram [DEPTH];
    logic                we;
    logic                l_d, w_d, r_d, s_d;

    logic [DATA_W-1:0]   instr;
    op_t                 op;
    logic [ADDR_W-1:0]   k;
    logic [DATA_W-1:0]   opnd;
    logic [DATA_W:0]     sum, diff;

    assign instr = rom(pc);
    assign op    = op_t'(instr[DATA_W-1 -: 4]);
    assign k     = instr[ADDR_W-1:0];
    assign opnd  = (op == OP_ADDI) ? DATA_W'(k) : ram[k];
    assign sum   = {1'b0, acc} + {1'b0, opnd};
    // Top bit of the widened difference is the borrow out.
    assign diff  = {1'b0, acc} - {1'b0, ram[k]};

    always_comb begin
        state_d = state;
        pc_d    = pc + ADDR_W'(1);
        acc_d   = acc;
        z_d     = z;
        c_d     = c;
        we      = 1'b0;
        l_d     = 1'b0;
        w_d     = 1'b0;
        r_d     = 1'b1;
        s_d     = 1'b0;
        if (state == ST_HALT) begin
            pc_d = pc;
            r_d  = 1'b0;
            s_d  = 1'b1;
        end else begin
            case (op)
                OP_LDI: begin
                    acc_d = DATA_W'(k);
                    z_d   = (k == '0);
                    l_d   = 1'b1;
                end
                OP_LDA: begin
                    acc_d = ram[k];
                    z_d   = (ram[k] == '0);
                    l_d   = 1'b1;
                end
                OP_STA: begin
                    we  = 1'b1;
                    w_d = 1'b1;
                end
                OP_ADD, OP_ADDI: begin
                    {c_d, acc_d} = sum;
                    z_d          = (sum[DATA_W-1:0] == '0);
                end
                OP_SUB: begin
                    {c_d, acc_d} = diff;
                    z_d          = (diff[DATA_W-1:0] == '0);
                end
                OP_JMP: pc_d = k;
                OP_JZ:  if (z) pc_d = k;
                OP_HLT: begin
                    pc_d    = pc;
                    state_d = ST_HALT;
                    r_d     = 1'b0;
                    s_d     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            pc    <= '0;
            acc   <= '0;
            z     <= 1'b0;
            c     <= 1'b0;
            L     <= 1'b0;
            W     <= 1'b0;
            R     <= 1'b0;
            S     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            acc   <= acc_d;
            z     <= z_d;
            c     <= c_d;
            L     <= l_d;
            W     <= w_d;
            R     <= r_d;
            S     <= s_d;
            if (we) ram[k] <= acc;
        end
    end

`ifdef MINI_DEBUG_PORTS_EN
    assign acc_dbg = acc;
    assign pc_dbg  = pc;
    assign z_dbg   = z;
`endif

endmodule

// File: tb/tb_mini_cpu.sv
// Directed bench for mini_cpu: runs the built-in program, halt, reset-restart and a slow-clock long run.
module tb_mini_cpu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic L, W, R, S;
    int   half = 5;
    int   n_assert = 0;
    int   n_fail = 0;

`ifdef MINI_DEBUG_PORTS_EN
    logic [7:0] acc_dbg;
    logic [3:0] pc_dbg;
    logic       z_dbg;
`endif

    mini_cpu dut (
        .clk (clk),
        .rst (rst),
        .L   (L),
        .W   (W),
        .R   (R),
        .S   (S)
`ifdef MINI_DEBUG_PORTS_EN
        ,
        .acc_dbg (acc_dbg),
        .pc_dbg  (pc_dbg),
        .z_dbg   (z_dbg)
`endif
    );

    always #(half) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Status outputs packed as {L,W,R,S}.
    function automatic logic [3:0] st();
        return {L, W, R, S};
    endfunction

    initial begin
        rst = 1'b1;
        edge1();
        edge1();
        chk("reset_lwrs", 32'(st()), 32'b0000);
        chk("reset_acc", 32'(dut.acc), 32'd0);
        chk("reset_pc", 32'(dut.pc), 32'd0);
`ifdef MINI_DEBUG_PORTS_EN
        chk("reset_acc_dbg", 32'(acc_dbg), 32'd0);
        chk("reset_pc_dbg", 32'(pc_dbg), 32'd0);
        chk("reset_z_dbg", 32'(z_dbg), 32'd0);
`endif

        rst = 1'b0;
        edge1();
        chk("e1_lwrs", 32'(st()), 32'b1010);
        chk("e1_acc", 32'(dut.acc), 32'd5);
        chk("e1_pc", 32'(dut.pc), 32'd1);
        edge1();
        chk("e2_lwrs", 32'(st()), 32'b0110);
        chk("e2_ram0", 32'(dut.ram[0]), 32'd5);
        edge1();
        chk("e3_lwrs", 32'(st()), 32'b1010);
        chk("e3_acc", 32'(dut.acc), 32'd3);
        edge1();
        chk("e4_lwrs", 32'(st()), 32'b0010);
        chk("e4_acc", 32'(dut.acc), 32'd8);
        chk("e4_zc", 32'({dut.z, dut.c}), 32'b00);
        edge1();
        chk("e5_lwrs", 32'(st()), 32'b0110);
        chk("e5_ram1", 32'(dut.ram[1]), 32'd8);
        edge1();
        chk("e6_lwrs", 32'(st()), 32'b1010);
        chk("e6_acc", 32'(dut.acc), 32'd8);
`ifdef MINI_DEBUG_PORTS_EN
        chk("e6_acc_dbg", 32'(acc_dbg), 32'd8);
        chk("e6_pc_dbg", 32'(pc_dbg), 32'd6);
`endif
        edge1();
        chk("e7_lwrs", 32'(st()), 32'b0001);
        chk("e7_pc", 32'(dut.pc), 32'd6);
        for (int i = 0; i < 500; i++) begin
            edge1();
            chk("halt_lwrs", 32'(st()), 32'b0001);
        end
        chk("halt_pc", 32'(dut.pc), 32'd6);
        chk("halt_acc", 32'(dut.acc), 32'd8);
        chk("halt_ram1", 32'(dut.ram[1]), 32'd8);

        rst = 1'b1;
        edge1();
        chk("rst2_lwrs", 32'(st()), 32'b0000);
        chk("rst2_pc", 32'(dut.pc), 32'd0);
        chk("rst2_acc", 32'(dut.acc), 32'd0);
        chk("rst2_ram0", 32'(dut.ram[0]), 32'd0);
        rst = 1'b0;
        edge1();
        chk("restart_lwrs", 32'(st()), 32'b1010);
        chk("restart_acc", 32'(dut.acc), 32'd5);

        // Slow clock: 100 ns half-period, 1000 half-periods.
        rst = 1'b1;
        half = 100;
        edge1();
        rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            edge1();
            chk("long_noX", 32'($isunknown(st())), 32'd0);
        end
        chk("long_final_lwrs", 32'(st()), 32'b0001);
        chk("long_final_acc", 32'(dut.acc), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
